// File: rtl/led_matrix_pwm_if.sv
// Scan-control bus between a frame source and the LED matrix PWM driver.
// The master side supplies enable and brightness; the slave side drives the LEDs.
interface led_matrix_pwm_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned BW   = 4
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                      en;
  logic [ROWS*COLS*BW-1:0]   bright;
  logic [COLS-1:0]           aled;
  logic [ROWS-1:0]           kled_tri;
  logic [RW-1:0]             row_idx;
  logic                      frame_start;

  modport master (output en, bright, input aled, kled_tri, row_idx, frame_start);
  modport slave  (input en, bright, output aled, kled_tri, row_idx, frame_start);
endinterface

// File: rtl/led_matrix_pwm.sv
// Row-scanned LED matrix driver: per-row blanking gap, then a BW-bit PWM ON phase.
// Brightness is latched into a shadow copy at each frame start so a frame never tears.
module led_matrix_pwm #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned BW       = 4,
  parameter int unsigned PRESCALE = 2,
  parameter int unsigned DEAD     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  led_matrix_pwm_if.slave   bus
);
  localparam int unsigned NSTEP = (1 << BW) - 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CMAX  = (DEAD > PRESCALE) ? DEAD : PRESCALE;
  localparam int unsigned CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned NB    = ROWS * COLS * BW;

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   t_q, t_d;
  logic [RW-1:0]   row_q, row_d;
  logic [NB-1:0]   shadow_q, shadow_d;
  logic [COLS-1:0] aled_q, aled_d;
  logic [ROWS-1:0] kled_q, kled_d;
  logic            fs_q, fs_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      t_q      <= '0;
      row_q    <= '0;
      shadow_q <= '0;
      aled_q   <= '1;
      kled_q   <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      row_q    <= row_d;
      shadow_q <= shadow_d;
      aled_q   <= aled_d;
      kled_q   <= kled_d;
      fs_q     <= fs_d;
    end
  end

  // Next state; cnt times the blanking gap in BLANK and the prescaler in ON
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_d      = t_q;
    row_d    = row_q;
    shadow_d = shadow_q;
    fs_d     = 1'b0;
    aled_d   = '1;
    kled_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d  = BLANK;
          cnt_d    = '0;
          t_d      = '0;
          row_d    = '0;
          fs_d     = 1'b1;
          shadow_d = bus.bright;
        end
      end
      BLANK: begin
        if (cnt_q == CW'(DEAD - 1)) begin
          state_d = ON;
          cnt_d   = '0;
          t_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ON: begin
        if (cnt_q == CW'(PRESCALE - 1)) begin
          cnt_d = '0;
          if (t_q == BW'(NSTEP - 1)) begin
            state_d = BLANK;
            t_d     = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d    = '0;
              fs_d     = 1'b1;
              shadow_d = bus.bright;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            t_d = t_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins from any state and discards the partial frame
    if (!bus.en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      t_d      = '0;
      row_d    = '0;
      fs_d     = 1'b0;
      shadow_d = shadow_q;
    end

    // Drive is derived from the upcoming state so outputs align with it
    if (state_d == ON) begin
      kled_d = ROWS'(1) << row_d;
      for (int c = 0; c < int'(COLS); c++) begin
        aled_d[c] = (t_d >= shadow_q[(int'(row_d) * int'(COLS) + c) * int'(BW) +: BW]);
      end
    end
  end

  assign bus.aled        = aled_q;
  assign bus.kled_tri    = kled_q;
  assign bus.row_idx     = row_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_led_matrix_pwm.sv
// Directed bench for led_matrix_pwm at default parameters (row 34 clk, frame 136 clk).
// Expected outputs come from the row/phase timing formula, sampled 1 ns after each edge.
module tb_led_matrix_pwm;
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned BW   = 4;
  localparam int ROW_T = 34;
  localparam int FRAME_T = 136;
  localparam logic [31:0] OFF_VEC = 32'h0000_000F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_matrix_pwm_if #(.ROWS(ROWS), .COLS(COLS), .BW(BW)) bus ();

  led_matrix_pwm #(
    .ROWS(ROWS), .COLS(COLS), .BW(BW), .PRESCALE(2), .DEAD(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_b [ROWS*COLS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {frame_start, row_idx, kled_tri, aled}
  function automatic logic [31:0] observed();
    return {21'd0, bus.frame_start, bus.row_idx, bus.kled_tri, bus.aled};
  endfunction

  // Cycle k of a frame: 4 blank cycles, then 15 ticks of 2 cycles per row
  function automatic logic [31:0] expected(input int k);
    int r;
    int ph;
    logic [3:0] kl;
    logic [3:0] al;
    r  = k / ROW_T;
    ph = k % ROW_T;
    kl = '0;
    al = '1;
    if (ph >= 4) begin
      kl[r] = 1'b1;
      for (int c = 0; c < int'(COLS); c++)
        if ((ph - 4) / 2 < exp_b[r*COLS + c]) al[c] = 1'b0;
    end
    return {21'd0, (k == 0), 2'(r), kl, al};
  endfunction

  task automatic drive_all(input int v);
    for (int i = 0; i < int'(ROWS*COLS); i++) bus.bright[i*BW +: BW] = 4'(v);
  endtask

  task automatic set_exp(input int v);
    for (int i = 0; i < int'(ROWS*COLS); i++) exp_b[i] = v;
  endtask

  task automatic run_frame(input string tag, input int ncyc, input int chg_at, input int chg_val);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s k=%0d", tag, k), observed(), expected(k));
      if (k == chg_at) drive_all(chg_val);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.bright = '1;
    set_exp(0);

    // Reset dominates even with en high
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset%0d", i), observed(), OFF_VEC);
    end

    drive_all(0);
    rst_n = 1'b1;
    run_frame("zero", FRAME_T, -1, 0);

    drive_all(0);
    bus.bright[(1*COLS + 2)*BW +: BW] = 4'd7;
    exp_b[1*COLS + 2] = 7;
    run_frame("led12", FRAME_T, -1, 0);

    drive_all(15);
    set_exp(15);
    run_frame("full", FRAME_T, -1, 0);

    // Mid-frame change must wait for the next frame_start
    drive_all(3);
    set_exp(3);
    run_frame("mid3", FRAME_T, 50, 12);
    set_exp(12);
    run_frame("next12", FRAME_T, -1, 0);

    // Drop en during row 2 ON (row 2 ON begins at k=72)
    run_frame("endrop", 81, -1, 0);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d", i), observed(), OFF_VEC);
    end
    bus.en = 1'b1;
    run_frame("enrestart", FRAME_T, -1, 0);

    // One-cycle reset during row 1 ON
    run_frame("rstmid", 40, -1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_pulse", observed(), OFF_VEC);
    rst_n = 1'b1;
    run_frame("rstrestart", FRAME_T, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_matrix_pwm.md
LED_MATRIX_PWM -- requirements
Module: led_matrix_pwm

Interface
REQ-001 Parameter ROWS, default 4, number of cathode rows (one-hot scanned), range 1..16.
REQ-002 Parameter COLS, default 4, number of anode columns driven in parallel per row, range 1..16.
REQ-003 Parameter BW, default 4, brightness bits per LED, range 1..8; NSTEP = 2^BW-1 PWM ticks per row.
REQ-004 Parameter PRESCALE, default 2, clk cycles per PWM tick, range 1..256.
REQ-005 Parameter DEAD, default 4, blanking clk cycles before each row's ON phase (anti-ghosting), range 1..256.
REQ-006 clk  input  1  system clock (48 MHz HFOSC domain); one clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 en  input  1  scan enable; low forces all LEDs off.
REQ-009 bright  input  ROWS*COLS*BW  brightness of LED (r,c) at bits [(r*COLS+c)*BW +: BW].
REQ-010 aled  output  COLS  anode drive, active-low (0 = column lit).
REQ-011 kled_tri  output  ROWS  cathode output-enable for external SB_IO tristate, one-hot or zero.
REQ-012 row_idx  output  clog2(ROWS) (min 1)  row currently scanned.
REQ-013 frame_start  output  1  one-cycle pulse at start of each frame.

Function
REQ-014 The block SHALL implement states IDLE, BLANK, ON.
REQ-015 IDLE: entered when en=0 (from any state, next cycle); aled all 1, kled_tri 0, row_idx 0; exits to BLANK of row 0 on the first cycle en=1.
REQ-016 BLANK: lasts exactly DEAD cycles; aled all 1, kled_tri 0; then enters ON.
REQ-017 ON: lasts NSTEP*PRESCALE cycles; kled_tri = one-hot(row_idx); tick counter t = 0..NSTEP-1 advances every PRESCALE cycles.
REQ-018 During ON, aled[c] SHALL be 0 iff t < shadow brightness of (row_idx,c); value 0 never lit, value NSTEP lit all ticks.
REQ-019 At ON end, row_idx SHALL increment and enter BLANK; after row ROWS-1 it wraps to 0.
REQ-020 Row period SHALL be DEAD + NSTEP*PRESCALE cycles; frame period ROWS times that.
REQ-021 frame_start SHALL pulse for one cycle on the first BLANK cycle of row 0 (including the first after IDLE/reset).
REQ-022 bright SHALL be copied to a shadow register on the same cycle frame_start is asserted; bright changes mid-frame SHALL NOT affect the current frame.
REQ-023 aled, kled_tri, row_idx, frame_start SHALL be registered; kled_tri and aled SHALL never both select a lit LED during BLANK or IDLE.
REQ-024 Row switching SHALL always pass through BLANK; kled_tri SHALL never change one-hot value without ≥DEAD cycles of zero between.
REQ-025 en deassert mid-ON SHALL blank outputs next cycle, discard the partial row, and restart at row 0 BLANK.
REQ-026 Counters SHALL be sized from parameters; no wrap of internal counters other than row_idx and t.

Reset
REQ-027 While rst_n=0 at a clk edge: state IDLE, aled all 1, kled_tri 0, row_idx 0, frame_start 0, shadow brightness 0, all counters 0.
REQ-028 First cycle after rst_n rises with en=1 SHALL enter BLANK row 0 with frame_start pulsing.
REQ-029 Reset asserted mid-operation SHALL override all other behaviour on that edge.

Verification (defaults: NSTEP=15, row period 34, frame 136 clk)
REQ-030 Reset, en=1, bright all 0 -> frame_start every 136 cycles; kled_tri cycles 0001,0010,0100,1000, each 30 cycles after 4 zero cycles; aled stays 1111.
REQ-031 LED(1,2)=7, others 0 -> in row 1 ON phase aled[2]=0 for exactly 14 cycles then 1 for 16; all other columns 1.
REQ-032 All bright=15 -> aled=0000 for whole 30-cycle ON phase of every row; 1111 during each 4-cycle BLANK.
REQ-033 Change bright mid-frame from 3 to 12 -> current frame still shows 6-cycle on-time; next frame (after frame_start) 24 cycles.
REQ-034 Drop en during row 2 ON -> next cycle aled=1111, kled_tri=0000; re-raise en -> frame_start pulse, row 0 BLANK restart.
REQ-035 Assert rst_n=0 for one cycle mid-ON -> reset values of REQ-027 on that edge; scan restarts per REQ-028.
